// File: rtl/clk_meter.sv
// clk_meter: frequency / period meter for slow clocks and strobes.
//
// The asynchronous input sig_in is brought into the clkin domain with a
// two-flop synchronizer followed by a history flop. Rising edges of the
// synchronized signal are counted over a gate window of GATE_CYCLES clkin
// cycles. The count is published as freq together with a one-cycle
// freq_valid pulse and a no_signal flag for a window that saw no edges.
//
// Optional feature, enabled by defining CLK_METER_PERIOD_EN:
//   period reports the number of clkin cycles between the last two detected
//   rising edges, independent of en and the gate FSM. When the macro is not
//   defined, period is constant 0.
//
// Parameters:
//   GATE_CYCLES : gate window length in clkin cycles (minimum 2)
//   CNT_W       : width of the freq and period counters
//
// Ports:
//   clkin      : system clock, all logic on its rising edge
//   rst        : synchronous, active-high reset
//   en         : measurement enable, level-sensitive
//   sig_in     : signal under test, asynchronous to clkin
//   freq       : rising edges counted in the last completed window
//   freq_valid : one-cycle pulse when freq updates
//   no_signal  : last completed window counted zero edges
//   busy       : a gate window is open
//   period     : clkin cycles between the last two detected edges
module clk_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             no_signal,
  output logic             busy,
  output logic [CNT_W-1:0] period
);

  localparam int unsigned      GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 32'd1);
  localparam logic [GW-1:0]    GATE_ONE  = GW'(32'd1);
  localparam logic [GW-1:0]    GATE_ZERO = GW'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  logic             s1_r, s2_r, s3_r;
  logic             edge_s;
  state_t           state_r, state_next_s;
  logic [GW-1:0]    gate_cnt_r, gate_cnt_next_s;
  logic [CNT_W-1:0] edge_cnt_r, edge_cnt_next_s;
  logic [CNT_W-1:0] edge_inc_s;
  logic [CNT_W-1:0] freq_r, freq_next_s;
  logic             freq_valid_r, freq_valid_next_s;
  logic             no_signal_r, no_signal_next_s;
  logic             busy_r, busy_next_s;

  // Synchronizer and history flops; run in every FSM state.
  always_ff @(posedge clkin) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign edge_s     = s2_r & ~s3_r;
  assign edge_inc_s = edge_s ? sat_inc(edge_cnt_r) : edge_cnt_r;

  // State, counters and registered outputs.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      gate_cnt_r   <= GATE_ZERO;
      edge_cnt_r   <= CNT_ZERO;
      freq_r       <= CNT_ZERO;
      freq_valid_r <= 1'b0;
      no_signal_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      gate_cnt_r   <= gate_cnt_next_s;
      edge_cnt_r   <= edge_cnt_next_s;
      freq_r       <= freq_next_s;
      freq_valid_r <= freq_valid_next_s;
      no_signal_r  <= no_signal_next_s;
      busy_r       <= busy_next_s;
    end
  end

  // Next-state and next-output logic. The result of the final gate cycle
  // (including that cycle's edge) is registered on the way into DONE, so
  // freq already holds the new value while freq_valid is high.
  always_comb begin
    state_next_s      = state_r;
    gate_cnt_next_s   = GATE_ZERO;
    edge_cnt_next_s   = CNT_ZERO;
    freq_next_s       = freq_r;
    freq_valid_next_s = 1'b0;
    no_signal_next_s  = no_signal_r;
    busy_next_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_next_s = ST_GATE;
          busy_next_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (gate_cnt_r == GATE_LAST) begin
          // Final cycle: completes even if en has just dropped.
          state_next_s      = ST_DONE;
          freq_next_s       = edge_inc_s;
          no_signal_next_s  = (edge_inc_s == CNT_ZERO);
          freq_valid_next_s = 1'b1;
        end else if (!en) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s    = ST_GATE;
          gate_cnt_next_s = gate_cnt_r + GATE_ONE;
          edge_cnt_next_s = edge_inc_s;
          busy_next_s     = 1'b1;
        end
      end
      ST_DONE: begin
        // Any edge seen in this cycle is dropped with the counter clear.
        if (en) begin
          state_next_s = ST_GATE;
          busy_next_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign freq       = freq_r;
  assign freq_valid = freq_valid_r;
  assign no_signal  = no_signal_r;
  assign busy       = busy_r;

`ifdef CLK_METER_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_r;
  logic [CNT_W-1:0] period_r;
  logic             armed_r;

  // Edge-to-edge cycle counter; the first edge after reset only arms it.
  always_ff @(posedge clkin) begin
    if (rst) begin
      per_cnt_r <= CNT_ZERO;
      period_r  <= CNT_ZERO;
      armed_r   <= 1'b0;
    end else if (edge_s) begin
      per_cnt_r <= CNT_ZERO;
      armed_r   <= 1'b1;
      if (armed_r) begin
        period_r <= sat_inc(per_cnt_r);
      end else begin
        period_r <= period_r;
      end
    end else begin
      per_cnt_r <= sat_inc(per_cnt_r);
      period_r  <= period_r;
      armed_r   <= armed_r;
    end
  end

  assign period = period_r;
`else
  assign period = CNT_ZERO;
`endif

endmodule

// File: tb/tb_clk_meter.sv
// Self-checking bench for clk_meter. Two instances share the stimulus:
// dut_a with a 100-cycle window and dut_b with the minimum 2-cycle window.
// The reference model keeps timestamps of detected edges and, when a window
// closes, counts the timestamps that fall inside that half-open interval.
module tb_clk_meter;

  localparam int GA = 100;
  localparam int GB = 2;
  localparam int CW = 32;

  logic          clkin = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] freq_a, period_a, freq_b, period_b;
  logic          fv_a, ns_a, busy_a, fv_b, ns_b, busy_b;

  clk_meter #(.GATE_CYCLES(GA), .CNT_W(CW)) dut_a (
    .clkin(clkin), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq_a), .freq_valid(fv_a), .no_signal(ns_a), .busy(busy_a),
    .period(period_a)
  );

  clk_meter #(.GATE_CYCLES(GB), .CNT_W(CW)) dut_b (
    .clkin(clkin), .rst(rst), .en(en), .sig_in(sig_in),
    .freq(freq_b), .freq_valid(fv_b), .no_signal(ns_b), .busy(busy_b),
    .period(period_b)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_err = 0;
  int t = 0;

  // Stimulus pattern: period sig_p with sig_h high cycles, 0 = held low.
  int sig_p = 10;
  int sig_h = 5;
  int sig_ph = 0;
  bit sig_rand = 1'b0;

  // Reference model state.
  int     gate_len[2];
  bit     m_open[2];
  bit     m_done[2];
  int     m_ws[2];
  longint m_freq[2];
  bit     m_ns[2];
  bit     m_fv[2];
  bit     m_busy[2];
  bit     hist[$];
  int     det_ts[$];
  bit     have_prev;
  int     prev_ts;
  longint m_period;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic drive_sig();
    if (sig_rand) begin
      sig_in = 1'($urandom_range(0, 1));
    end else if (sig_p == 0) begin
      sig_in = 1'b0;
    end else begin
      sig_in = (sig_ph < sig_h);
      sig_ph = (sig_ph + 1) % sig_p;
    end
  endtask

  task automatic model_reset_hist();
    hist.delete();
    repeat (3) hist.push_back(1'b0);
  endtask

  // Model update at a rising clkin edge, using the inputs present there.
  task automatic model_step();
    bit det;
    int n;
    t++;
    if (rst) begin
      model_reset_hist();
      det_ts.delete();
      have_prev = 1'b0;
      m_period  = 0;
      for (int i = 0; i < 2; i++) begin
        m_open[i] = 1'b0; m_done[i] = 1'b0; m_freq[i] = 0;
        m_ns[i] = 1'b0; m_fv[i] = 1'b0; m_busy[i] = 1'b0;
      end
    end else begin
      // A synchronized rise becomes visible two samples after it was taken.
      det = hist[1] & ~hist[0];
      void'(hist.pop_front());
      hist.push_back(sig_in);
      if (det) begin
        det_ts.push_back(t);
        if (have_prev) m_period = longint'(t - prev_ts);
        prev_ts   = t;
        have_prev = 1'b1;
      end
      while (det_ts.size() > 0 && det_ts[0] < t - 400) void'(det_ts.pop_front());
      for (int i = 0; i < 2; i++) begin
        m_fv[i] = 1'b0;
        if (m_done[i]) begin
          m_done[i] = 1'b0;
          if (en) begin m_open[i] = 1'b1; m_ws[i] = t + 1; end
        end else if (m_open[i]) begin
          if (t == m_ws[i] + gate_len[i] - 1) begin
            n = 0;
            foreach (det_ts[j]) if (det_ts[j] >= m_ws[i] && det_ts[j] <= t) n++;
            m_freq[i] = n;
            m_ns[i]   = (n == 0);
            m_fv[i]   = 1'b1;
            m_open[i] = 1'b0;
            m_done[i] = 1'b1;
          end else if (!en) begin
            m_open[i] = 1'b0;
          end
        end else if (en) begin
          m_open[i] = 1'b1;
          m_ws[i]   = t + 1;
        end
        m_busy[i] = m_open[i];
      end
    end
  endtask

  task automatic compare();
    longint exp_per;
`ifdef CLK_METER_PERIOD_EN
    exp_per = m_period;
`else
    exp_per = 0;
`endif
    check_eq("a.freq", 64'(freq_a), m_freq[0]);
    check_eq("a.freq_valid", 64'(fv_a), 64'(m_fv[0]));
    check_eq("a.no_signal", 64'(ns_a), 64'(m_ns[0]));
    check_eq("a.busy", 64'(busy_a), 64'(m_busy[0]));
    check_eq("a.period", 64'(period_a), exp_per);
    check_eq("b.freq", 64'(freq_b), m_freq[1]);
    check_eq("b.freq_valid", 64'(fv_b), 64'(m_fv[1]));
    check_eq("b.no_signal", 64'(ns_b), 64'(m_ns[1]));
    check_eq("b.busy", 64'(busy_b), 64'(m_busy[1]));
    check_eq("b.period", 64'(period_b), exp_per);
  endtask

  // One clkin cycle: drive at the falling edge, model at the rising edge,
  // compare at the next falling edge.
  task automatic tick();
    drive_sig();
    @(posedge clkin);
    model_step();
    @(negedge clkin);
    compare();
  endtask

  task automatic wait_fv(input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (fv_a) begin
        at = t;
        break;
      end
    end
    if (at < 0) check_eq("fv_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int t1, t2, seg;
    longint exp_p;
    gate_len[0] = GA;
    gate_len[1] = GB;
    model_reset_hist();
    have_prev = 1'b0;
    m_period  = 0;
    @(negedge clkin);

    // Reset state.
    rst = 1'b1; en = 1'b0; sig_p = 10; sig_h = 5; sig_ph = 0;
    repeat (3) tick();
    check_eq("rst.freq", 64'(freq_a), 64'd0);
    check_eq("rst.busy", 64'(busy_a), 64'd0);
    check_eq("rst.valid", 64'(fv_a), 64'd0);

    // P=10 with en held: 10 edges per window, pulses every GA+1 cycles.
    rst = 1'b0; en = 1'b1;
    wait_fv(300, t1);
    wait_fv(300, t2);
    check_eq("p10.interval", 64'(t2 - t1), 64'(GA + 1));
    check_eq("p10.freq", 64'(freq_a), 64'd10);
    check_eq("p10.no_signal", 64'(ns_a), 64'd0);

    // Input held low: zero edges, no_signal set.
    sig_p = 0;
    wait_fv(300, t1);
    wait_fv(300, t2);
    check_eq("low.freq", 64'(freq_a), 64'd0);
    check_eq("low.no_signal", 64'(ns_a), 64'd1);

    // Complete a P=10 window, then abort a P=4 window at gate cycle 50.
    sig_p = 10; sig_h = 5; sig_ph = 0;
    wait_fv(300, t1);
    wait_fv(300, t2);
    check_eq("abort.pre_freq", 64'(freq_a), 64'd10);
    sig_p = 4; sig_h = 2; sig_ph = 0;
    repeat (50) tick();
    en = 1'b0;
    tick();
    check_eq("abort.busy", 64'(busy_a), 64'd0);
    repeat (150) tick();
    check_eq("abort.freq", 64'(freq_a), 64'd10);

    // Reset in the middle of a window.
    sig_p = 10; sig_h = 5; sig_ph = 0; en = 1'b1;
    wait_fv(300, t1);
    wait_fv(300, t2);
    check_eq("mid.pre_freq", 64'(freq_a), 64'd10);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    check_eq("mid.freq", 64'(freq_a), 64'd0);
    check_eq("mid.valid", 64'(fv_a), 64'd0);
    check_eq("mid.no_signal", 64'(ns_a), 64'd0);
    check_eq("mid.busy", 64'(busy_a), 64'd0);
    check_eq("mid.period", 64'(period_a), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("mid.busy_rise", 64'(busy_a), 64'd1);

    // Period with the meter disabled.
    en = 1'b0;
    repeat (40) tick();
`ifdef CLK_METER_PERIOD_EN
    exp_p = 10;
`else
    exp_p = 0;
`endif
    check_eq("period.p10", 64'(period_a), 64'(exp_p));

    // Minimum window with P=3 (1 high, 2 low).
    sig_p = 3; sig_h = 1; sig_ph = 0; en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (fv_b) check_eq("g2.freq_le1", 64'(freq_b <= 1), 64'd1);
    end

    // Randomized segments: pattern, enable and occasional reset.
    for (int s = 0; s < 40; s++) begin
      sig_rand = ($urandom_range(0, 7) == 0);
      sig_p = $urandom_range(3, 12);
      sig_h = $urandom_range(1, sig_p - 1);
      sig_ph = 0;
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      seg = $urandom_range(20, 150);
      repeat (seg) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
